// File: rtl/mem_access_pkg.sv
// Shared CPU package: memory FSM states, ALU source selectors
// and default datapath width used by the load/store stage.
package mem_access_pkg;

  localparam int DATA_WID_DEF = 16;
  localparam int CNT_WID      = 4;

  typedef enum logic [1:0] {
    ALU_SRC_REG = 2'd0,
    ALU_SRC_IMM = 2'd1,
    ALU_SRC_PC  = 2'd2
  } alu_src_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } mem_state_e;

endpackage

// File: rtl/mem_access.sv
// Load/store unit driving an asynchronous SRAM with
// setup, strobe and hold phases; freezes the pipeline meanwhile.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int DATA_WID = DATA_WID_DEF,
  parameter int ADDR_WID = 18,
  parameter int WAIT_CYC = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mem_read,
  input  logic                mem_write,
  input  logic [DATA_WID-1:0] addr,
  input  logic [DATA_WID-1:0] memdata,
  output logic [DATA_WID-1:0] rdata,
  output logic                stall,
  output logic [ADDR_WID-1:0] ram_addr,
  output logic [DATA_WID-1:0] ram_wdata,
  input  logic [DATA_WID-1:0] ram_rdata,
  output logic                ram_drive,
  output logic                ram_ce_n,
  output logic                ram_oe_n,
  output logic                ram_we_n
);

  localparam logic [CNT_WID-1:0] CNT_LOAD =
    CNT_WID'(WAIT_CYC - 1);

  mem_state_e          state_q, state_d;
  logic [CNT_WID-1:0]  cnt_q, cnt_d;
  logic [DATA_WID-1:0] addr_q, addr_d;
  logic [DATA_WID-1:0] data_q, data_d;
  logic [DATA_WID-1:0] rdata_q, rdata_d;
  logic                wr_q, wr_d;
  logic                req;

  assign req = mem_read | mem_write;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      rdata_q <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rdata_q <= rdata_d;
      wr_q    <= wr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    data_d    = data_q;
    rdata_d   = rdata_q;
    wr_d      = wr_q;
    stall     = 1'b0;
    ram_ce_n  = 1'b1;
    ram_oe_n  = 1'b1;
    ram_we_n  = 1'b1;
    ram_drive = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          stall   = 1'b1;
          addr_d  = addr;
          data_d  = memdata;
          // a store wins when both requests are raised
          wr_d    = mem_write;
          state_d = SETUP;
        end
      end
      SETUP: begin
        stall     = 1'b1;
        ram_ce_n  = 1'b0;
        ram_drive = wr_q;
        cnt_d     = CNT_LOAD;
        state_d   = ACCESS;
      end
      ACCESS: begin
        stall     = 1'b1;
        ram_ce_n  = 1'b0;
        ram_drive = wr_q;
        ram_we_n  = ~wr_q;
        ram_oe_n  = wr_q;
        if (cnt_q == '0) begin
          state_d = DONE;
          if (!wr_q) rdata_d = ram_rdata;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        ram_ce_n  = 1'b0;
        ram_drive = wr_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign ram_addr  = ADDR_WID'(addr_q);
  assign ram_wdata = data_q;
  assign rdata     = rdata_q;

endmodule
